// File: rtl/whitetile_pkg.sv
// Shared types and defaults for the whitetile key front end.
// Optional feature macro used by the key blocks: KEY_DEBOUNCE_REPEAT_EN (auto-repeat).
package whitetile_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  localparam int STABLE_TICKS_DEF = 4;
  localparam int REPEAT_DELAY_DEF = 50;
  localparam int REPEAT_RATE_DEF  = 10;

endpackage

// File: rtl/debounce_cell.sv
// One key: 2-flop synchronizer, four-state debounce FSM, registered level/press/release.
// Auto-repeat presses are built only when KEY_DEBOUNCE_REPEAT_EN is defined.
module debounce_cell
  import whitetile_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
`ifdef KEY_DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic          r_sync1, r_sync2;
  key_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level, r_press, r_release;
  logic [CW:0]   w_cnt_inc;
  logic          w_done;

  // In RELEASED/PRESSED the counter sits at 0, so w_done there means STABLE_TICKS == 1.
  assign w_cnt_inc = {1'b0, r_cnt} + (CW+1)'(1);
  assign w_done    = (w_cnt_inc == (CW+1)'(STABLE_TICKS));

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] r_rcnt;
  logic          r_rphase;
  logic [RW-1:0] w_rinc, w_rlim;

  // Phase 0 waits out the initial delay, phase 1 paces the following repeats.
  assign w_rinc = r_rcnt + RW'(1);
  assign w_rlim = r_rphase ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
`endif

  // NOTE: non-blocking assignments let both stages sample pre-edge values; blocking ones would collapse the synchronizer into a single flop.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; a synchronous reset is never placed in the sensitivity list.
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      r_rcnt    <= '0;
      r_rphase  <= 1'b0;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (i_tick) begin
        case (r_state)
          RELEASED, PRESS_CHK: begin
            if (!r_sync2) begin
              r_state <= RELEASED;
              r_cnt   <= '0;
            end else if (w_done) begin
              r_state <= PRESSED;
              r_cnt   <= '0;
              r_level <= 1'b1;
              r_press <= 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
              r_rcnt   <= '0;
              r_rphase <= 1'b0;
`endif
            end else begin
              r_state <= PRESS_CHK;
              r_cnt   <= w_cnt_inc[CW-1:0];
            end
          end
          PRESSED, RELEASE_CHK: begin
            if (r_sync2) begin
              r_state <= PRESSED;
              r_cnt   <= '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
              if (r_state == RELEASE_CHK) begin
                r_rcnt   <= '0;
                r_rphase <= 1'b0;
              end else if (w_rinc == w_rlim) begin
                r_press  <= 1'b1;
                r_rcnt   <= '0;
                r_rphase <= 1'b1;
              end else begin
                r_rcnt <= w_rinc;
              end
`endif
            end else if (w_done) begin
              r_state   <= RELEASED;
              r_cnt     <= '0;
              r_level   <= 1'b0;
              r_release <= 1'b1;
            end else begin
              r_state <= RELEASE_CHK;
              r_cnt   <= w_cnt_inc[CW-1:0];
            end
          end
          default: begin
            r_state <= RELEASED;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Key front end: sample-tick generation from a clkdiv tap plus one debounce_cell per key.
// Define KEY_DEBOUNCE_REPEAT_EN to enable auto-repeat press pulses.
module key_debounce
  import whitetile_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_tap,
  input  logic [N_KEYS-1:0] keys_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  logic r_tap_q;
  logic w_tick;

  // Resetting the delayed tap high blocks a spurious tick right after reset.
  always_ff @(posedge clk) begin
    if (rst) r_tap_q <= 1'b1;
    else     r_tap_q <= clk_tap;
  end

  assign w_tick = clk_tap & ~r_tap_q;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    debounce_cell #(
      .STABLE_TICKS(STABLE_TICKS)
`ifdef KEY_DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
`endif
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .i_tick   (w_tick),
      .i_key    (keys_in[g]),
      .o_level  (key_level[g]),
      .o_press  (key_press[g]),
      .o_release(key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus randomized key activity
// against a run-length reference model (consecutive differing samples flip the level).
module tb_key_debounce;

  localparam int NK = 4;
  localparam int ST = 4;
`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int RD = 5;
  localparam int RR = 2;
`else
  localparam int RD = 50;
  localparam int RR = 10;
`endif

  logic          clk, rst, clk_tap;
  logic [NK-1:0] keys_in, key_level, key_press, key_release;

  key_debounce #(
    .N_KEYS(NK), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .clk_tap(clk_tap), .keys_in(keys_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tap toggles every 4 clocks: one rising edge (tick) per 8 cycles.
  int tap_div = 0;
  initial clk_tap = 1'b0;
  always @(posedge clk) begin
    #1;
    if (tap_div == 3) begin
      tap_div = 0;
      clk_tap = ~clk_tap;
    end else begin
      tap_div = tap_div + 1;
    end
  end

  // Reference model: two-cycle sample delay, tick on tap rising edge, and per key a
  // count of consecutive ticks disagreeing with the accepted level.
  logic [NK-1:0] m_s1, m_s2, m_lvl, exp_press, exp_release;
  logic          m_tapq;
  int            m_run[NK];
  int            m_hold[NK];

  always @(posedge clk) begin
    logic          tick;
    logic [NK-1:0] ks;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_tapq = 1'b1; m_lvl = '0;
      exp_press = '0; exp_release = '0;
      for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_hold[k] = 0; end
    end else begin
      tick   = clk_tap & ~m_tapq;
      ks     = m_s2;
      m_tapq = clk_tap;
      m_s2   = m_s1;
      m_s1   = keys_in;
      exp_press = '0; exp_release = '0;
      if (tick) begin
        for (int k = 0; k < NK; k++) begin
          if (ks[k] == m_lvl[k]) begin
            if (m_lvl[k]) begin
              if (m_run[k] != 0) m_hold[k] = 0;
              else begin
                m_hold[k]++;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                if (m_hold[k] == RD || (m_hold[k] > RD && (m_hold[k] - RD) % RR == 0))
                  exp_press[k] = 1'b1;
`endif
              end
            end
            m_run[k] = 0;
          end else begin
            m_run[k]++;
            if (m_run[k] == ST) begin
              m_lvl[k]  = ks[k];
              m_run[k]  = 0;
              m_hold[k] = 0;
              if (ks[k]) exp_press[k] = 1'b1;
              else       exp_release[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Per-scenario observation counters, accumulated while stepping.
  int            d_press[NK], d_rel[NK], m_pcnt[NK];
  int            mism, bad_rise, both_hi;
  bit            seen_1001;
  logic [NK-1:0] lvl_and, prev_lvl;

  task automatic clear_stats();
    for (int k = 0; k < NK; k++) begin d_press[k] = 0; d_rel[k] = 0; m_pcnt[k] = 0; end
    mism = 0; bad_rise = 0; both_hi = 0; seen_1001 = 1'b0;
    lvl_and = '1; prev_lvl = key_level;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        d_press[k] += int'(key_press[k]);
        d_rel[k]   += int'(key_release[k]);
        m_pcnt[k]  += int'(exp_press[k]);
        if (key_press[k] && !(key_level[k] && (!prev_lvl[k] || m_hold[k] != 0))) bad_rise++;
      end
      if ({key_level, key_press, key_release} !== {m_lvl, exp_press, exp_release}) mism++;
      if (key_press == 4'b1001) seen_1001 = 1'b1;
      if ((key_press & key_release) != '0) both_hi++;
      lvl_and  = lvl_and & key_level;
      prev_lvl = key_level;
    end
  endtask

  task automatic drive(input logic [NK-1:0] v);
    @(posedge clk); #1 keys_in = v;
  endtask

  task automatic test_reset();
    clear_stats();
    step(3);
    n_checks++; if (key_level !== 4'b0) begin n_errors++; $display("FAIL reset_level: got %b want 0000", key_level); end
    n_checks++; if (key_press !== 4'b0) begin n_errors++; $display("FAIL reset_press: got %b want 0000", key_press); end
    n_checks++; if (key_release !== 4'b0) begin n_errors++; $display("FAIL reset_release: got %b want 0000", key_release); end
    @(posedge clk); #1 rst = 1'b0;
    clear_stats();
    step(24);
    n_checks++; if (d_press[0] + d_press[1] + d_press[2] + d_press[3] !== 0) begin n_errors++; $display("FAIL idle_no_press: got %0d pulses want 0", d_press[0] + d_press[1] + d_press[2] + d_press[3]); end
    n_checks++; if (mism !== 0) begin n_errors++; $display("FAIL idle_model: got %0d differing cycles want 0", mism); end
  endtask

  task automatic test_clean_press();
    clear_stats();
    drive(4'b0001);
    step(100);
    n_checks++; if (d_press[0] !== m_pcnt[0]) begin n_errors++; $display("FAIL clean_press_vs_model: got %0d want %0d", d_press[0], m_pcnt[0]); end
`ifndef KEY_DEBOUNCE_REPEAT_EN
    n_checks++; if (d_press[0] !== 1) begin n_errors++; $display("FAIL clean_press_count: got %0d want 1", d_press[0]); end
`endif
    n_checks++; if (bad_rise !== 0) begin n_errors++; $display("FAIL clean_press_level_align: got %0d bad pulses want 0", bad_rise); end
    n_checks++; if (key_level[0] !== 1'b1) begin n_errors++; $display("FAIL clean_press_level: got %b want 1", key_level[0]); end
    clear_stats();
    drive(4'b0000);
    step(60);
    n_checks++; if (d_rel[0] !== 1) begin n_errors++; $display("FAIL clean_release_count: got %0d want 1", d_rel[0]); end
    n_checks++; if (key_level[0] !== 1'b0) begin n_errors++; $display("FAIL clean_release_level: got %b want 0", key_level[0]); end
  endtask

  task automatic test_bounce();
    clear_stats();
    drive(4'b0010); step(24);
    drive(4'b0000); step(8);
    drive(4'b0010); step(24);
    n_checks++; if (d_press[1] !== 0) begin n_errors++; $display("FAIL bounce_early_press: got %0d want 0", d_press[1]); end
    step(24);
    n_checks++; if (d_press[1] !== 1) begin n_errors++; $display("FAIL bounce_press_count: got %0d want 1", d_press[1]); end
    n_checks++; if (mism !== 0) begin n_errors++; $display("FAIL bounce_model: got %0d differing cycles want 0", mism); end
    drive(4'b0000); step(48);
  endtask

  task automatic test_release_bounce();
    drive(4'b0001); step(56);
    clear_stats();
    drive(4'b0000); step(16);
    drive(4'b0001); step(8);
    drive(4'b0000); step(26);
    n_checks++; if (lvl_and[0] !== 1'b1) begin n_errors++; $display("FAIL rel_bounce_level_held: got %b want 1", lvl_and[0]); end
    n_checks++; if (d_rel[0] !== 0) begin n_errors++; $display("FAIL rel_bounce_early_release: got %0d want 0", d_rel[0]); end
    step(24);
    n_checks++; if (d_rel[0] !== 1) begin n_errors++; $display("FAIL rel_bounce_release_count: got %0d want 1", d_rel[0]); end
    n_checks++; if (key_level[0] !== 1'b0) begin n_errors++; $display("FAIL rel_bounce_final_level: got %b want 0", key_level[0]); end
  endtask

  task automatic test_simultaneous();
    clear_stats();
    drive(4'b1001); step(60);
    n_checks++; if (seen_1001 !== 1'b1) begin n_errors++; $display("FAIL simul_press_1001: got %b want 1", seen_1001); end
    n_checks++; if (d_press[0] !== 1 || d_press[3] !== 1) begin n_errors++; $display("FAIL simul_press_counts: got %0d/%0d want 1/1", d_press[0], d_press[3]); end
    drive(4'b0000); step(60);
    n_checks++; if (d_rel[0] !== 1 || d_rel[3] !== 1) begin n_errors++; $display("FAIL simul_release_counts: got %0d/%0d want 1/1", d_rel[0], d_rel[3]); end
    n_checks++; if (mism !== 0) begin n_errors++; $display("FAIL simul_model: got %0d differing cycles want 0", mism); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    drive(4'b0100);
    for (int i = 0; i < 100 && !found; i++) begin
      step(1);
      if (m_run[2] == 3) found = 1'b1;
    end
    n_checks++; if (!found) begin n_errors++; $display("FAIL reset_mid_reach_cnt3: got timeout want PRESS_CHK cnt 3"); end
    clear_stats();
    @(posedge clk); #1 rst = 1'b1;
    step(2);
    n_checks++; if ({key_level, key_press, key_release} !== 12'b0) begin n_errors++; $display("FAIL reset_mid_outputs: got %b/%b/%b want all 0", key_level, key_press, key_release); end
    n_checks++; if (d_press[2] !== 0) begin n_errors++; $display("FAIL reset_mid_no_pulse: got %0d want 0", d_press[2]); end
    @(posedge clk); #1 rst = 1'b0;
    clear_stats();
    step(24);
    n_checks++; if (d_press[2] !== 0) begin n_errors++; $display("FAIL reset_mid_early_press: got %0d want 0", d_press[2]); end
    step(24);
    n_checks++; if (d_press[2] !== 1) begin n_errors++; $display("FAIL reset_mid_press_count: got %0d want 1", d_press[2]); end
    n_checks++; if (mism !== 0) begin n_errors++; $display("FAIL reset_mid_model: got %0d differing cycles want 0", mism); end
    drive(4'b0000); step(48);
  endtask

  task automatic test_repeat();
    bit found = 1'b0;
    clear_stats();
    drive(4'b0001);
    for (int i = 0; i < 100 && !found; i++) begin
      step(1);
      if (d_press[0] != 0) found = 1'b1;
    end
    n_checks++; if (!found) begin n_errors++; $display("FAIL repeat_first_press: got timeout want pulse"); end
    step(120);
`ifdef KEY_DEBOUNCE_REPEAT_EN
    n_checks++; if (d_press[0] !== 7) begin n_errors++; $display("FAIL repeat_pulse_count: got %0d want 7", d_press[0]); end
`else
    n_checks++; if (d_press[0] !== 1) begin n_errors++; $display("FAIL hold_single_press: got %0d want 1", d_press[0]); end
`endif
    n_checks++; if (mism !== 0) begin n_errors++; $display("FAIL repeat_model: got %0d differing cycles want 0", mism); end
    drive(4'b0000); step(48);
  endtask

  task automatic test_random();
    int left[NK];
    int reported = 0;
    int pulses = 0;
    for (int k = 0; k < NK; k++) left[k] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NK; k++) begin
        left[k]--;
        if (left[k] <= 0) begin
          keys_in[k] = ~keys_in[k];
          left[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : $urandom_range(20, 70);
        end
      end
      @(negedge clk);
      pulses += $countones(key_press);
      n_checks++;
      if ({key_level, key_press, key_release} !== {m_lvl, exp_press, exp_release}) begin
        n_errors++;
        if (reported < 10) begin
          reported++;
          $display("FAIL random_cycle_%0d: got lvl/press/rel %b/%b/%b want %b/%b/%b",
                   c, key_level, key_press, key_release, m_lvl, exp_press, exp_release);
        end
      end
      n_checks++;
      if ((key_press & key_release) !== 4'b0) begin n_errors++; $display("FAIL random_excl_%0d: got press %b release %b want disjoint", c, key_press, key_release); end
    end
    n_checks++; if (pulses == 0) begin n_errors++; $display("FAIL random_activity: got 0 presses want some"); end
    keys_in = '0;
    step(60);
  endtask

  initial begin
    rst = 1'b1;
    keys_in = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
